// File: rtl/secure_subsys_isolation_ctrl_if.sv
// Control/status bundle between the host-side control logic and the secure
// subsystem isolation sequencer.
//
// Handshake semantics: every signal here is a level, sampled on the rising
// edge of the sequencer clock. boot_en_i and isolate_req_i are held requests
// (isolate_req_i wins whenever both are high). axi_isolated_i is the status
// returned by the AXI isolate stage. clear_fault_i is a one-cycle pulse that
// only has meaning while fault_o is high. The sequencer never waits on a
// ready; the host observes progress through busy_o, fault_o and state_o.
interface secure_subsys_isolation_ctrl_if;
    logic       boot_en_i;
    logic       isolate_req_i;
    logic       axi_isolated_i;
    logic       clear_fault_i;
    logic       axi_isolate_o;
    logic       fetch_en_o;
    logic       busy_o;
    logic       fault_o;
    logic [2:0] state_o;

    modport master (
        output boot_en_i,
        output isolate_req_i,
        output axi_isolated_i,
        output clear_fault_i,
        input  axi_isolate_o,
        input  fetch_en_o,
        input  busy_o,
        input  fault_o,
        input  state_o
    );

    modport slave (
        input  boot_en_i,
        input  isolate_req_i,
        input  axi_isolated_i,
        input  clear_fault_i,
        output axi_isolate_o,
        output fetch_en_o,
        output busy_o,
        output fault_o,
        output state_o
    );
endinterface

// File: rtl/secure_subsys_isolation_ctrl.sv
// Sequencer for the secure subsystem outbound AXI path and core start-up.
// Releases AXI isolation, waits for the port to open, lets it settle, then
// enables instruction fetch. Re-isolates on request and waits for drain.
// Both waits on the AXI isolate stage are bounded; expiry latches FAULT.
module secure_subsys_isolation_ctrl #(
    parameter int TimeoutCycles = 1024,
    parameter int SettleCycles  = 4,
    parameter int CntWidth      = $clog2(TimeoutCycles + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    secure_subsys_isolation_ctrl_if.slave  ctrl
);

    typedef enum logic [2:0] {
        ST_ISOLATED = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_RUN      = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    localparam logic [CntWidth-1:0] CntTimeoutLast = CntWidth'(TimeoutCycles - 1);
    localparam logic [CntWidth-1:0] CntSettleLast  = CntWidth'(SettleCycles - 1);
    localparam logic [CntWidth-1:0] CntMax         = CntWidth'(TimeoutCycles);

    state_e              state_q;
    state_e              state_d;
    logic [CntWidth-1:0] cnt_q;
    logic                axi_isolate_q;
    logic                fetch_en_q;
    logic                busy_q;
    logic                fault_q;

    // Next-state selection; isolation requests outrank boot everywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ISOLATED: begin
                if (ctrl.boot_en_i && !ctrl.isolate_req_i) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (ctrl.isolate_req_i)            state_d = ST_DRAIN;
                else if (!ctrl.axi_isolated_i)     state_d = ST_SETTLE;
                else if (cnt_q == CntTimeoutLast)  state_d = ST_FAULT;
            end
            ST_SETTLE: begin
                if (ctrl.isolate_req_i)            state_d = ST_DRAIN;
                else if (cnt_q == CntSettleLast)   state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ctrl.isolate_req_i)            state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Drain completion beats a coincident timeout.
                if (ctrl.axi_isolated_i)           state_d = ST_ISOLATED;
                else if (cnt_q == CntTimeoutLast)  state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (ctrl.clear_fault_i)            state_d = ST_ISOLATED;
            end
            default: state_d = ST_FAULT;
        endcase
    end

    // State, wait counter and registered Moore outputs (decoded from next state).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_ISOLATED;
            cnt_q         <= '0;
            axi_isolate_q <= 1'b1;
            fetch_en_q    <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q inside {ST_RELEASE, ST_SETTLE, ST_DRAIN}) begin
                if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end

            axi_isolate_q <= state_d inside {ST_ISOLATED, ST_DRAIN, ST_FAULT};
            busy_q        <= state_d inside {ST_RELEASE, ST_SETTLE, ST_DRAIN};
            fault_q       <= (state_d == ST_FAULT);

            // Fetch enable is sticky: once the core is started it keeps running.
            if (state_d == ST_RUN && state_q != ST_RUN) fetch_en_q <= 1'b1;
        end
    end

    assign ctrl.axi_isolate_o = axi_isolate_q;
    assign ctrl.fetch_en_o    = fetch_en_q;
    assign ctrl.busy_o        = busy_q;
    assign ctrl.fault_o       = fault_q;
    assign ctrl.state_o       = state_q;

endmodule

// File: tb/tb_secure_subsys_isolation_ctrl.sv
// Bench for secure_subsys_isolation_ctrl: directed sequences from the
// operating rules followed by randomized traffic, every cycle scored against
// a behavioural model kept in this file.
module tb_secure_subsys_isolation_ctrl;

    localparam int TO = 16;
    localparam int SC = 4;

    // Phase numbers as the host sees them on state_o.
    localparam int P_ISO = 0, P_REL = 1, P_SET = 2, P_RUN = 3, P_DRN = 4, P_FLT = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    secure_subsys_isolation_ctrl_if dut_if ();

    secure_subsys_isolation_ctrl #(
        .TimeoutCycles(TO),
        .SettleCycles (SC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .ctrl (dut_if)
    );

    // ---------------- scoreboard ----------------
    int         n_cmp = 0;
    int         n_err = 0;
    logic [6:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the phase, how many full cycles have been spent in it, and
    // whether the core has ever been started.
    int m_phase;
    int m_dwell;
    bit m_fetch;

    function automatic void model_reset();
        m_phase = P_ISO;
        m_dwell = 0;
        m_fetch = 1'b0;
    endfunction

    function automatic void model_step(input bit boot, input bit req, input bit isod, input bit clr);
        int nxt;
        int this_cycle;
        nxt        = m_phase;
        this_cycle = m_dwell + 1;   // ordinal of the cycle that this edge closes
        if (m_phase == P_ISO) begin
            if (boot && !req) nxt = P_REL;
        end else if (m_phase == P_REL) begin
            if (req) nxt = P_DRN;
            else if (!isod) nxt = P_SET;
            else if (this_cycle == TO) nxt = P_FLT;
        end else if (m_phase == P_SET) begin
            if (req) nxt = P_DRN;
            else if (this_cycle == SC) nxt = P_RUN;
        end else if (m_phase == P_RUN) begin
            if (req) nxt = P_DRN;
        end else if (m_phase == P_DRN) begin
            if (isod) nxt = P_ISO;
            else if (this_cycle == TO) nxt = P_FLT;
        end else begin
            if (clr) nxt = P_ISO;
        end
        if (nxt != m_phase) begin
            m_dwell = 0;
            if (nxt == P_RUN) m_fetch = 1'b1;
        end else begin
            m_dwell = this_cycle;
        end
        m_phase = nxt;
    endfunction

    function automatic logic [6:0] model_outputs();
        bit iso, busy, flt;
        iso  = (m_phase == P_ISO) || (m_phase == P_DRN) || (m_phase == P_FLT);
        busy = (m_phase == P_REL) || (m_phase == P_SET) || (m_phase == P_DRN);
        flt  = (m_phase == P_FLT);
        return {m_fetch, iso, busy, flt, 3'(m_phase)};
    endfunction

    task automatic score();
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL exp_q: got empty queue expected one entry");
        end else begin
            e = exp_q.pop_front();
            check_eq("state",       dut_if.state_o,       e[2:0]);
            check_eq("fault",       dut_if.fault_o,       e[3]);
            check_eq("busy",        dut_if.busy_o,        e[4]);
            check_eq("axi_isolate", dut_if.axi_isolate_o, e[5]);
            check_eq("fetch_en",    dut_if.fetch_en_o,    e[6]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drive, let the DUT sample, score at the next falling edge.
    task automatic cycle(input bit boot, input bit req, input bit isod, input bit clr);
        dut_if.boot_en_i      = boot;
        dut_if.isolate_req_i  = req;
        dut_if.axi_isolated_i = isod;
        dut_if.clear_fault_i  = clr;
        @(posedge clk);
        model_step(boot, req, isod, clr);
        exp_q.push_back(model_outputs());
        @(negedge clk);
        score();
    endtask

    // Asserted between clock edges; outputs must react before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_eq({tag, "_fetch"},   dut_if.fetch_en_o,    0);
        check_eq({tag, "_isolate"}, dut_if.axi_isolate_o, 1);
        check_eq({tag, "_state"},   dut_if.state_o,       P_ISO);
        check_eq({tag, "_busy"},    dut_if.busy_o,        0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic goto_run();
        int guard;
        guard = 0;
        cycle(1, 0, 1, 0);
        while (dut_if.state_o != 3'(P_RUN) && guard < 20) begin
            cycle(1, 0, 0, 0);
            guard++;
        end
        check_eq("goto_run", dut_if.state_o, P_RUN);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int busy_cnt;
        bit a_lvl;

        rst                   = 1'b1;
        dut_if.boot_en_i      = 1'b0;
        dut_if.isolate_req_i  = 1'b0;
        dut_if.axi_isolated_i = 1'b1;
        dut_if.clear_fault_i  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset values
        check_eq("rst_state",   dut_if.state_o,       0);
        check_eq("rst_isolate", dut_if.axi_isolate_o, 1);
        check_eq("rst_fetch",   dut_if.fetch_en_o,    0);
        check_eq("rst_busy",    dut_if.busy_o,        0);
        check_eq("rst_fault",   dut_if.fault_o,       0);
        rst = 1'b0;

        // Boot: port opens 3 cycles after isolate falls
        cycle(1, 0, 1, 0);
        check_eq("boot_release", dut_if.state_o, P_REL);
        check_eq("boot_iso_low", dut_if.axi_isolate_o, 0);
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 0);
        check_eq("boot_settle", dut_if.state_o, P_SET);
        n = 0;
        do begin
            cycle(1, 0, 0, 0);
            n++;
        end while (dut_if.fetch_en_o == 1'b0 && n < 20);
        check_eq("boot_settle_len", n, SC);
        check_eq("boot_run", dut_if.state_o, P_RUN);

        // Drain: port reports isolated 10 cycles after the request
        cycle(1, 1, 0, 0);
        check_eq("drain_state", dut_if.state_o, P_DRN);
        check_eq("drain_iso", dut_if.axi_isolate_o, 1);
        busy_cnt = 1;
        for (int i = 0; i < 9; i++) begin
            cycle(1, 1, 0, 0);
            busy_cnt += int'(dut_if.busy_o);
        end
        cycle(1, 1, 1, 0);
        busy_cnt += int'(dut_if.busy_o);
        check_eq("drain_done", dut_if.state_o, P_ISO);
        check_eq("drain_busy_len", busy_cnt, 10);
        check_eq("drain_fetch_kept", dut_if.fetch_en_o, 1);
        cycle(0, 0, 1, 0);

        // Drain timeout
        goto_run();
        cycle(1, 1, 0, 0);
        n = 0;
        while (dut_if.state_o != 3'(P_FLT) && n < 40) begin
            cycle(1, 1, 0, 0);
            n++;
        end
        check_eq("timeout_len", n, TO);
        check_eq("timeout_fault", dut_if.fault_o, 1);
        check_eq("timeout_iso", dut_if.axi_isolate_o, 1);
        cycle(1, 0, 1, 0);
        cycle(1, 1, 0, 0);
        check_eq("fault_sticky", dut_if.state_o, P_FLT);
        cycle(0, 0, 0, 1);
        check_eq("fault_clear", dut_if.state_o, P_ISO);
        cycle(0, 0, 1, 1);
        check_eq("clear_outside_fault", dut_if.state_o, P_ISO);

        // Completion coincides with the last timeout cycle
        cycle(1, 0, 1, 0);
        cycle(1, 1, 1, 0);
        check_eq("coin_drain", dut_if.state_o, P_DRN);
        for (int i = 0; i < TO - 1; i++) cycle(0, 1, 0, 0);
        check_eq("coin_still_drain", dut_if.state_o, P_DRN);
        cycle(0, 1, 1, 0);
        check_eq("coin_completion", dut_if.state_o, P_ISO);
        check_eq("coin_no_fault", dut_if.fault_o, 0);
        cycle(0, 0, 1, 0);

        // Reset mid-operation
        goto_run();
        async_reset("rst_in_run");

        // Abort during settle
        cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        check_eq("abort_drain", dut_if.state_o, P_DRN);
        check_eq("abort_fetch_low", dut_if.fetch_en_o, 0);
        cycle(1, 1, 1, 0);
        cycle(0, 0, 1, 0);

        // Randomized traffic
        a_lvl = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) a_lvl = ~a_lvl;
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
            else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                       a_lvl, $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
